// File: rtl/intadd_pkg.sv
// Shared types for the intadd issue path: precision codes, the 11-bit
// cru_intadd control word, and the control half of a queued add command.
package intadd_pkg;

    localparam logic [1:0] PREC_32 = 2'b11;
    localparam logic [1:0] PREC_8  = 2'b00;

    // Control word driven to intadd; field order matches the wire order.
    typedef struct packed {
        logic       inst_valid;
        logic [1:0] prec_s0;
        logic [1:0] prec_s1;
        logic [1:0] prec_s2;
        logic       sign_s0;
        logic       sign_s1;
        logic       sign_s2;
        logic       update_st;
    } cru_intadd_t;

    // Per-command control fields; sign is {sign_s0, sign_s1, sign_s2}.
    typedef struct packed {
        logic [1:0] prec;
        logic [2:0] sign;
        logic       update_st;
    } intadd_cmd_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } issue_state_t;

    // Only the two defined precision modes are legal.
    function automatic logic prec_legal(input logic [1:0] p);
        return (p == PREC_32) || (p == PREC_8);
    endfunction

    // Build the control word for one beat; update_st only rides the last beat.
    function automatic cru_intadd_t make_cru(input intadd_cmd_t c, input logic last);
        cru_intadd_t w;
        w.inst_valid = 1'b1;
        w.prec_s0    = c.prec;
        w.prec_s1    = c.prec;
        w.prec_s2    = c.prec;
        w.sign_s0    = c.sign[2];
        w.sign_s1    = c.sign[1];
        w.sign_s2    = c.sign[0];
        w.update_st  = c.update_st & last;
        return w;
    endfunction

endpackage

// File: rtl/intadd_cmd_fifo.sv
// Small synchronous FIFO for queued add commands. full/empty are registered,
// so a push is refused while full even if the head is popped that cycle.
module intadd_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    // Storage array; contents need no reset since empty guards reads.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers and registered occupancy flags; pointers wrap at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/intadd_issue.sv
// Microinstruction issuer for intadd: queues macro add commands and expands
// each into back-to-back beats through a 3-stage pipeline
// (S0 register-file read, S1 cru_intadd, S2 write-back strobe).
module intadd_issue
    import intadd_pkg::*;
#(
    parameter int CMD_DEPTH = 2,
    parameter int ADDR_W    = 5,
    parameter int BEAT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_prec,
    input  logic [2:0]        cmd_sign,
    input  logic              cmd_update_st,
    input  logic [ADDR_W-1:0] cmd_src0_addr,
    input  logic [ADDR_W-1:0] cmd_src1_addr,
    input  logic [ADDR_W-1:0] cmd_src2_addr,
    input  logic [ADDR_W-1:0] cmd_dst_addr,
    input  logic [BEAT_W-1:0] cmd_beats,
    input  logic              stall,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr0,
    output logic [ADDR_W-1:0] rf_rd_addr1,
    output logic [ADDR_W-1:0] rf_rd_addr2,
    output logic [10:0]       cru_intadd,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_last,
    output logic              busy,
    output logic              err
);

    localparam int CMD_W = $bits(intadd_cmd_t) + 4 * ADDR_W + BEAT_W;

    logic [CMD_W-1:0]  fifo_in, fifo_out;
    logic              fifo_full, fifo_empty, fifo_pop;
    intadd_cmd_t       cmd_ctl, head_ctl;
    logic [ADDR_W-1:0] head_src0, head_src1, head_src2, head_dst;
    logic [BEAT_W-1:0] head_beats;

    issue_state_t      state;
    intadd_cmd_t       ctl;
    logic [ADDR_W-1:0] src0, src1, src2, dst;
    logic [BEAT_W-1:0] beat, last_beat;
    logic              issue, is_last, head_legal, load;

    cru_intadd_t       cru_q;
    logic [ADDR_W-1:0] s1_wb_addr;
    logic              s1_last;
    logic [2:1]        vld_pipe;

    assign cmd_ctl = '{prec: cmd_prec, sign: cmd_sign, update_st: cmd_update_st};
    assign fifo_in = {cmd_ctl, cmd_src0_addr, cmd_src1_addr, cmd_src2_addr,
                      cmd_dst_addr, cmd_beats};
    assign {head_ctl, head_src0, head_src1, head_src2, head_dst, head_beats} = fifo_out;

    intadd_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready = !fifo_full;

    // A beat leaves S0 whenever the FSM holds a command and is not stalled.
    // The head is popped from IDLE, or on the last beat for a zero-bubble reload.
    assign issue      = (state == ISSUE) && !stall;
    assign is_last    = (beat == last_beat);
    assign head_legal = prec_legal(head_ctl.prec);
    assign fifo_pop   = !fifo_empty && ((state == IDLE) || (issue && is_last));
    assign load       = fifo_pop && head_legal;

    // S0 outputs are driven straight from the beat being issued this cycle.
    assign rf_rd_en    = issue;
    assign rf_rd_addr0 = issue ? src0 + ADDR_W'(beat) : '0;
    assign rf_rd_addr1 = issue ? src1 + ADDR_W'(beat) : '0;
    assign rf_rd_addr2 = issue ? src2 + ADDR_W'(beat) : '0;

    // Command FSM: pop/load, beat counting, illegal-precision error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ctl       <= '0;
            src0      <= '0;
            src1      <= '0;
            src2      <= '0;
            dst       <= '0;
            beat      <= '0;
            last_beat <= '0;
            err       <= 1'b0;
        end else begin
            err <= fifo_pop && !head_legal;
            if (load) begin
                ctl       <= head_ctl;
                src0      <= head_src0;
                src1      <= head_src1;
                src2      <= head_src2;
                dst       <= head_dst;
                beat      <= '0;
                last_beat <= head_beats;
            end else if (issue && !is_last) begin
                beat <= beat + 1'b1;
            end
            if (fifo_pop)
                state <= head_legal ? ISSUE : IDLE;
            else if (issue && is_last)
                state <= IDLE;
        end
    end

    // S1/S2 pipeline: control word aligned with RF data, then write-back strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            cru_q      <= '0;
            s1_wb_addr <= '0;
            s1_last    <= 1'b0;
            wb_addr    <= '0;
            wb_last    <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[1], issue};
            cru_q      <= issue ? make_cru(ctl, is_last) : '0;
            s1_wb_addr <= issue ? dst + ADDR_W'(beat) : '0;
            s1_last    <= issue && is_last;
            wb_addr    <= s1_wb_addr;
            wb_last    <= s1_last;
        end
    end

    assign cru_intadd = cru_q;
    assign wb_valid   = vld_pipe[2];
    assign busy       = (state != IDLE) || (|vld_pipe);

endmodule
